instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage that feeds the decode stage. It drives a PC-based byte address into the
//  combinational instruction cache and captures the returned word with its PC in a small
//  queue. It presents the result to decode over a valid/ready handshake. It also handles
//  PC redirects from branch/jump resolution by flushing the queue and restarting fetch.
// PARAMETERS
//  ADDR_BITS    8     byte-address width; matches cache (64 words x 4 bytes)
//  WORD_BITS    32    instruction width
//  RESET_PC     '0    PC loaded on reset; must be word aligned
//  QUEUE_DEPTH  2     fetch queue entries; power of 2, >= 2
// PORTS
//  clk             in   1          clock; all state updates on rising edge
//  rst             in   1          synchronous, active-high reset
//  fetch_en        in   1          1 = fetch allowed; 0 = hold PC, queue still drains
//  imem_address    out  ADDR_BITS  byte address to the instruction cache (= pc)
//  imem_rd_data    in   WORD_BITS  word returned combinationally in the same cycle
//  redirect_valid  in   1          1-cycle pulse: load new PC, flush queue
//  redirect_pc     in   ADDR_BITS  target PC; bits [1:0] ignored (forced 0)
//  inst_valid      out  1          queue head holds a valid instruction
//  inst_ready      in   1          decode accepts the head this cycle
//  inst_data       out  WORD_BITS  head instruction word
//  inst_pc         out  ADDR_BITS  PC of the head instruction
// BEHAVIOUR
//  Reset: pc=RESET_PC, queue empty, state=IDLE, inst_valid=0, inst_data=0, inst_pc=0.
//  FSM: IDLE -> FETCH when fetch_en=1. FETCH -> IDLE when fetch_en=0.
//   A redirect is accepted in either state and does not change state.
//  pop  = inst_valid & inst_ready.
//  push = state==FETCH & !redirect_valid & (!full | pop).
//   On push, {imem_rd_data, pc} enters the queue tail and pc <= pc+4.
//   The PC wraps modulo 2^ADDR_BITS. No overflow flag.
//  Full queue with simultaneous pop: push and pop both occur; occupancy is unchanged.
//  Empty queue: no bypass. A word pushed in cycle N is visible at the head in N+1.
//  Redirect has priority over everything. In that cycle: queue cleared, no push, and the
//   pop is discarded (the handshake is ignored). pc <= {redirect_pc[ADDR_BITS-1:2],2'b00}.
//  Redirect latency: pulse in cycle N, imem_address = target in N+1,
//   inst_valid with the target instruction in N+2 (if fetch_en=1).
//  Stability rule: while inst_valid=1 and inst_ready=0, inst_data and inst_pc hold
//   unless a redirect occurs.
//  fetch_en=0 mid-stream: the PC freezes and the queued entries are still delivered.
//  rst asserted mid-operation: returns to the reset values on the next edge, overriding redirect.
//  inst_data and inst_pc read 0 when the queue is empty.
// CONFIGURATION
//  Macro FETCH_PERF_EN:
//   Defined: adds outputs perf_fetched[31:0] (count of pushes) and perf_stall[31:0]
//    (cycles in FETCH that are full without pop and have no redirect).
//    Both counters reset to 0, saturate at all-ones, and are unaffected by redirects.
//   Undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package fetch_pkg: typedef fetch_state_t {IDLE, FETCH}; typedef struct fetch_entry_t
//   {logic [WORD_BITS-1:0] inst; logic [ADDR_BITS-1:0] pc;}; constant INST_BYTES=4.
//  Sub-module fetch_queue: a synchronous FIFO of fetch_entry_t with a flush input and
//   push/pop/full/empty signals. Supports simultaneous push and pop when full.
//  Top level holds the PC register, FSM, push/pop logic and the optional counters.
// TESTING
//  1 Reset, fetch_en=1, inst_ready=1: imem_address 0,4,8,...; inst_pc 0,4,8 from cycle 2,
//    one instruction per cycle, inst_data = cache word at each PC.
//  2 inst_ready=0 for 5 cycles: the queue fills to 2, pc stops at 8, and head {pc 0} is stable.
//    Then release: pops of pc 0,4,8 occur with no gap.
//  3 redirect_pc=0x22 while the queue is full: the next cycle the queue is empty and
//    imem_address=0x20. The cycle after, inst_pc=0x20. The old entries are never accepted.
//  4 PC wrap: redirect to 0xFC, ready=1: delivered PCs are 0xFC, 0x00, 0x04.
//  5 fetch_en dropped with 2 queued: both delivered, then inst_valid=0, imem_address frozen.
//    Re-enable resumes at the frozen PC.
//  6 FETCH_PERF_EN: 10 accepted plus 3 full-stall cycles gives perf_fetched=10+queued and
//    perf_stall=3. rst mid-run clears both counters, the queue, and the PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Entry widths match the default 8-bit byte address and 32-bit instruction word.
package fetch_pkg;

  localparam int FETCH_ADDR_BITS = 8;
  localparam int FETCH_WORD_BITS = 32;
  localparam int INST_BYTES      = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_WORD_BITS-1:0] inst;
    logic [FETCH_ADDR_BITS-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {inst, pc} entries with a single-cycle flush.
// Latency: a push is visible at the head the following cycle; no bypass.
// Backpressure: full blocks pushes unless a pop happens in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  fetch_entry_t        mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [CNT_BITS-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_BITS'(1);
        2'b01:   count <= count - CNT_BITS'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_BITS'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, IDLE/FETCH FSM, redirect/flush handling and fetch queue.
// Optional macro FETCH_PERF_EN adds saturating push and full-stall counters.
// Latency: fetch to decode-visible is one cycle; redirect to target at head is two cycles.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  ADDR_BITS   = FETCH_ADDR_BITS,
  parameter int                  WORD_BITS   = FETCH_WORD_BITS,
  parameter logic [ADDR_BITS-1:0] RESET_PC   = '0,
  parameter int                  QUEUE_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  output logic [ADDR_BITS-1:0] imem_address,
  input  logic [WORD_BITS-1:0] imem_rd_data,
  input  logic                 redirect_valid,
  input  logic [ADDR_BITS-1:0] redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [WORD_BITS-1:0] inst_data,
  output logic [ADDR_BITS-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall
`endif
);

  fetch_state_t         state, state_next;
  logic [ADDR_BITS-1:0] pc;
  logic                 pop, push, full, empty;
  fetch_entry_t         wr_entry, head;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_en)  state_next = FETCH;
      FETCH:   if (!fetch_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign pop  = inst_valid & inst_ready;
  assign push = (state == FETCH) & ~redirect_valid & (~full | pop);

  // Low address bits of a redirect target are dropped to keep the PC word aligned.
  always_ff @(posedge clk) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc & ~ADDR_BITS'(3);
    else if (push)           pc <= pc + ADDR_BITS'(INST_BYTES);
  end

  assign wr_entry.inst = imem_rd_data;
  assign wr_entry.pc   = pc;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign imem_address = pc;
  assign inst_valid   = ~empty;
  assign inst_data    = head.inst;
  assign inst_pc      = head.pc;

`ifdef FETCH_PERF_EN
  logic stall;
  assign stall = (state == FETCH) & full & ~pop & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push && perf_fetched != '1)  perf_fetched <= perf_fetched + 32'd1;
      if (stall && perf_stall != '1)   perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
